pci_arbiter: RTL
================

Name: pci_arbiter

Overview:
- Central PCI bus arbiter that shares the AD/C_BE bus among N_DEV PCI_DEV-style agents.
- Each agent drives an active-high REQ and receives an active-high GNT.
- Grants rotate round-robin; a grant is issued only when the bus is idle.
- The arbiter monitors the shared FRAME and IRDY lines to track transaction start/end and enforces a grant-acceptance timeout.

Parameters:
N_DEV, 4, number of requesting agents (1..16)
GNT_TIMEOUT, 16, cycles a granted agent has to assert FRAME before GNT is withdrawn
OWN_W, 2, width of BUS_OWNER; must equal max(1, clog2(N_DEV))

Ports:
CLK  input  1  bus clock; all state changes on rising edge
RST  input  1  asynchronous, active-high reset
REQ  input  N_DEV  per-agent bus request, active-high
FRAME  input  1  shared PCI FRAME, active-low (0 = transaction in progress)
IRDY  input  1  shared PCI IRDY, active-low
GNT  output  N_DEV  per-agent grant, active-high, one-hot or zero
BUS_OWNER  output  OWN_W  index of agent last granted or currently owning the bus
BUS_BUSY  output  1  high from FRAME assertion until the turnaround cycle ends
TIMEOUT_EVT  output  1  one-cycle pulse when a grant is withdrawn for timeout

Behaviour:
- Reset, asynchronous and immediate:
  - GNT=0, BUS_OWNER=0, BUS_BUSY=0, TIMEOUT_EVT=0.
  - state=IDLE, rr_ptr=0, tmo_cnt=0.
- Bus idle means FRAME==1 && IRDY==1, sampled at the edge.
- IDLE:
  - If bus idle and REQ!=0, select the first set REQ bit searching from rr_ptr upward, wrapping mod N_DEV.
  - Next edge: GNT[sel]=1, BUS_OWNER=sel, tmo_cnt=0, state GRANTED.
  - Latency: REQ sampled high at edge k → GNT high after edge k.
  - If the bus is not idle (foreign or stale transaction), stay in IDLE with GNT=0.
- GRANTED:
  - FRAME sampled 0 → GNT=0, BUS_BUSY=1, rr_ptr=(owner+1) mod N_DEV, state BUSY.
  - Else if REQ[owner]==0 → GNT=0, rr_ptr=(owner+1) mod N_DEV, state IDLE. No TIMEOUT_EVT.
  - Else if tmo_cnt==GNT_TIMEOUT-1 → GNT=0, TIMEOUT_EVT=1 for one cycle, rr_ptr=(owner+1) mod N_DEV, state IDLE.
  - Else tmo_cnt+1.
  - Priority when several hold on the same edge: FRAME assertion > REQ drop > timeout.
- BUSY:
  - GNT=0 throughout; no hidden or overlapped arbitration.
  - When FRAME==1 && IRDY==1 are sampled: state TURN. BUS_BUSY stays 1.
  - FRAME=1 with IRDY=0 is the final data phase; remain in BUSY.
- TURN:
  - One mandatory idle cycle.
  - Next edge: BUS_BUSY=0, state IDLE. New REQs are evaluated from IDLE on the following edge, giving a minimum 2-cycle gap between transactions.
- Round-robin rules:
  - rr_ptr wraps N_DEV-1 → 0.
  - The last owner always has lowest priority next round.
  - With all REQ held high, grants cycle 0,1,2,3,0…
- BUS_OWNER holds its value after the transaction until the next grant.
- GNT is never multi-hot, and never nonzero outside GRANTED.
- FRAME=0 seen while in IDLE is treated as bus-not-idle. No state change.
- Reset asserted mid-transaction: GNT drops asynchronously; the arbiter restarts in IDLE and waits for bus idle before granting.

Decomposition:
- Shared include pci_arb_defs.vh:
  - state encodings IDLE=2'd0, GRANTED=2'd1, BUSY=2'd2, TURN=2'd3
  - default GNT_TIMEOUT
  - active-low level constants for FRAME/IRDY (ASSERTED=1'b0)
- Sub-module rr_pick:
  - Purely combinational; inputs REQ and rr_ptr, outputs valid and sel index.
  - Implemented as a double-width masked priority search.
- The FSM, timeout counter and pointer live in pci_arbiter.

Test Plan:
- Single request: REQ=4'b0100 at edge 1, bus idle → GNT=4'b0100 after edge 1, BUS_OWNER=2. FRAME=0 at edge 3 → GNT=0, BUS_BUSY=1. FRAME=1/IRDY=1 at edge 6 → BUS_BUSY=0 after edge 7.
- Round-robin fairness: REQ=4'b1111 held, each grantee runs a 2-cycle transaction → grant order 0,1,2,3,0. No agent is granted twice before the others.
- Timeout: REQ=4'b0010, FRAME never asserted → GNT[1] high for exactly 16 cycles, TIMEOUT_EVT pulses once, next grant goes to another requester if present.
- Request withdrawal: agent 3 granted, REQ[3] drops 2 cycles later → GNT=0 next edge, no TIMEOUT_EVT, rr_ptr=0.
- Busy bus: FRAME=0 held with REQ=4'b0001 in IDLE → GNT stays 0 until FRAME=1 and IRDY=1 are sampled.
- Async reset: RST pulsed between edges during BUSY → GNT=0 and BUS_BUSY=0 immediately. After release with REQ=4'b1000 and bus idle, first grant goes to agent 3 (search from 0).

Source files
------------

// File: rtl/pci_arbiter_pkg.sv
// Shared definitions for the PCI bus arbiter: FSM states, default timeout
// and the level constants for the active-low FRAME/IRDY lines.
package pci_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

  localparam int DEF_GNT_TIMEOUT = 16;

  // FRAME and IRDY are active-low on the PCI bus.
  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Round-robin request picker. Duplicates the request vector, masks the
// copy below the pointer and takes the lowest set bit, so the search starts
// at ptr and wraps back around through the unmasked upper copy.
module pci_arbiter_rr_pick #(
  parameter int N_DEV = 4,
  parameter int OWN_W = 2
) (
  input  logic [N_DEV-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic             vld,
  output logic [OWN_W-1:0] sel
);

  logic [2*N_DEV-1:0] dbl;

  // Masked double-width priority search; lowest surviving bit wins.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N_DEV; i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    vld = |req;
    sel = '0;
    for (int i = 2*N_DEV-1; i >= 0; i--) begin
      if (dbl[i]) sel = (i >= N_DEV) ? OWN_W'(i - N_DEV) : OWN_W'(i);
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grants issued only on an idle bus,
// transaction tracking from FRAME/IRDY, a mandatory turnaround cycle, and
// withdrawal of grants that are not accepted within GNT_TIMEOUT cycles.
module pci_arbiter
  import pci_arbiter_pkg::*;
#(
  parameter int N_DEV       = 4,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int OWN_W       = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_DEV-1:0] REQ,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic [N_DEV-1:0] GNT,
  output logic [OWN_W-1:0] BUS_OWNER,
  output logic             BUS_BUSY,
  output logic             TIMEOUT_EVT
);

  localparam int TMO_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);

  arb_state_t       state;
  logic [OWN_W-1:0] rr_ptr;
  logic [TMO_W-1:0] tmo_cnt;
  logic             pick_vld;
  logic [OWN_W-1:0] pick_sel;
  logic [N_DEV-1:0] pick_onehot;
  logic [OWN_W-1:0] owner_next;
  logic             bus_idle;

  assign bus_idle   = (FRAME == DEASSERTED) && (IRDY == DEASSERTED);
  // The agent just served drops to lowest priority for the next round.
  assign owner_next = (BUS_OWNER == OWN_W'(N_DEV - 1)) ? '0 : OWN_W'(BUS_OWNER + 1'b1);

  pci_arbiter_rr_pick #(
    .N_DEV(N_DEV),
    .OWN_W(OWN_W)
  ) u_pick (
    .req(REQ),
    .ptr(rr_ptr),
    .vld(pick_vld),
    .sel(pick_sel)
  );

  // Decode the picked index into the grant vector to be registered.
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < N_DEV; i++) begin
      pick_onehot[i] = (pick_sel == OWN_W'(i));
    end
  end

  // Arbitration FSM with registered grant, owner, busy and timeout outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      GNT         <= '0;
      BUS_OWNER   <= '0;
      BUS_BUSY    <= 1'b0;
      TIMEOUT_EVT <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
    end else begin
      TIMEOUT_EVT <= 1'b0;
      unique case (state)
        IDLE: begin
          // A foreign or stale transaction on the bus blocks any new grant.
          if (bus_idle && pick_vld) begin
            GNT       <= pick_onehot;
            BUS_OWNER <= pick_sel;
            tmo_cnt   <= '0;
            state     <= GRANTED;
          end
        end
        GRANTED: begin
          if (FRAME == ASSERTED) begin
            GNT      <= '0;
            BUS_BUSY <= 1'b1;
            rr_ptr   <= owner_next;
            state    <= BUSY;
          end else if (!REQ[BUS_OWNER]) begin
            GNT    <= '0;
            rr_ptr <= owner_next;
            state  <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            GNT         <= '0;
            TIMEOUT_EVT <= 1'b1;
            rr_ptr      <= owner_next;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        BUSY: begin
          // FRAME high with IRDY still low is the last data phase.
          if (bus_idle) state <= TURN;
        end
        TURN: begin
          BUS_BUSY <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
